// File: rtl/pipe_stage_hs_pkg.sv
// pipe_stage_hs_pkg: shared definitions for the handshaked pipeline stage register.
//   - Bit positions of the common control-bundle fields carried between stages.
//   - Stage occupancy state encoding used by the stage FSM.
package pipe_stage_hs_pkg;

  localparam int unsigned CTRL_BRANCH   = 0;
  localparam int unsigned CTRL_MEMTOREG = 1;
  localparam int unsigned CTRL_MEMWRITE = 2;
  localparam int unsigned CTRL_REGWRITE = 3;
  localparam int unsigned CTRL_ADDERSEL = 4;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_stage_hs_if.sv
// pipe_stage_hs_if: valid/ready handshake channel carrying a data and a control bundle.
//   valid : producer has an entry
//   ready : consumer can accept (transfer when valid & ready)
//   data  : DATA_W data bundle
//   ctrl  : CTRL_W control bundle
// master drives valid/data/ctrl and samples ready; slave is the mirror image.
interface pipe_stage_hs_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 8
) ();

  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [CTRL_W-1:0] ctrl;

  modport master (output valid, output data, output ctrl, input ready);
  modport slave  (input valid, input data, input ctrl, output ready);

endinterface

// File: rtl/pipe_stage_hs_slot.sv
// pipe_stage_hs_slot: one entry of the stage (valid + data + ctrl register).
//   i_clk    : rising-edge clock
//   i_clr    : synchronous clear (reset or flush); wins over load/unload
//   i_load   : capture i_data/i_ctrl and mark valid
//   i_unload : mark invalid (contents left in place)
//   i_data   : data bundle to capture
//   i_ctrl   : control bundle to capture
//   o_valid  : entry held
//   o_data   : held data bundle
//   o_ctrl   : held control bundle
module pipe_stage_hs_slot
  import pipe_stage_hs_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned CTRL_W   = 8,
  parameter int unsigned CLR_DATA = 1
) (
  input  logic              i_clk,
  input  logic              i_clr,
  input  logic              i_load,
  input  logic              i_unload,
  input  logic [DATA_W-1:0] i_data,
  input  logic [CTRL_W-1:0] i_ctrl,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [CTRL_W-1:0] o_ctrl
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [CTRL_W-1:0] r_ctrl;

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      // With CLR_DATA=0 the data flops carry no reset/clear at all.
      if (CLR_DATA != 0) r_data <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_ctrl  <= i_ctrl;
    end else if (i_unload) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_ctrl  = r_ctrl;

endmodule

// File: rtl/pipe_stage_hs.sv
// pipe_stage_hs: handshaked inter-stage pipeline register with flush and optional skid entry.
//   i_clk       : rising-edge clock
//   i_reset     : synchronous active-high reset
//   i_flush     : squash all held entries and any same-cycle incoming entry
//   i_up        : upstream channel (slave): valid/data/ctrl in, ready out
//   o_dn        : downstream channel (master): valid/data/ctrl out, ready in;
//                 ctrl forced to 0 while valid is low
//   o_occupancy : number of entries held (0..2, at most 1 when SKID=0)
// SKID=1 keeps a second entry so upstream ready is a pure register output;
// SKID=0 has a single entry with ready = !out_valid | out_ready.
module pipe_stage_hs
  import pipe_stage_hs_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned CTRL_W   = 8,
  parameter int unsigned SKID     = 1,
  parameter int unsigned CLR_DATA = 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_flush,
  pipe_stage_hs_if.slave        i_up,
  pipe_stage_hs_if.master       o_dn,
  output logic [1:0]            o_occupancy
);

  state_e            r_state;
  state_e            w_state_nxt;
  logic              w_clr;
  logic              w_in_ready;
  logic              w_in_fire;
  logic              w_out_fire;
  logic              w_main_load;
  logic              w_main_unload;
  logic              w_main_from_skid;
  logic              w_skid_load;
  logic              w_skid_unload;
  logic              w_main_valid;
  logic [DATA_W-1:0] w_main_data;
  logic [CTRL_W-1:0] w_main_ctrl;
  logic [DATA_W-1:0] w_main_din;
  logic [CTRL_W-1:0] w_main_cin;
  logic              w_skid_valid;
  logic [DATA_W-1:0] w_skid_data;
  logic [CTRL_W-1:0] w_skid_ctrl;

  assign w_clr = i_reset | i_flush;

  // SKID=1: ready depends on state only, so no out_ready -> in_ready path exists.
  assign w_in_ready = (SKID != 0) ? (r_state != ST_SKID) : (!w_main_valid || o_dn.ready);
  assign w_in_fire  = i_up.valid & w_in_ready;
  assign w_out_fire = w_main_valid & o_dn.ready;

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= ST_EMPTY;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_main_load      = 1'b0;
    w_main_unload    = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_load      = 1'b0;
    w_skid_unload    = 1'b0;
    if (i_flush) begin
      // Slots are cleared directly by w_clr; an incoming fire is simply not loaded.
      w_state_nxt = ST_EMPTY;
    end else begin
      unique case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            w_state_nxt = ST_FULL;
            w_main_load = 1'b1;
          end
        end
        ST_FULL: begin
          if (w_in_fire && w_out_fire) begin
            w_main_load = 1'b1;
          end else if (w_in_fire) begin
            // Only reachable with SKID=1: downstream stalled, park the new entry.
            w_state_nxt = ST_SKID;
            w_skid_load = 1'b1;
          end else if (w_out_fire) begin
            w_state_nxt   = ST_EMPTY;
            w_main_unload = 1'b1;
          end
        end
        ST_SKID: begin
          if (w_out_fire) begin
            w_state_nxt      = ST_FULL;
            w_main_load      = 1'b1;
            w_main_from_skid = 1'b1;
            w_skid_unload    = 1'b1;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  assign w_main_din = w_main_from_skid ? w_skid_data : i_up.data;
  assign w_main_cin = w_main_from_skid ? w_skid_ctrl : i_up.ctrl;

  pipe_stage_hs_slot #(
    .DATA_W   (DATA_W),
    .CTRL_W   (CTRL_W),
    .CLR_DATA (CLR_DATA)
  ) u_main (
    .i_clk    (i_clk),
    .i_clr    (w_clr),
    .i_load   (w_main_load),
    .i_unload (w_main_unload),
    .i_data   (w_main_din),
    .i_ctrl   (w_main_cin),
    .o_valid  (w_main_valid),
    .o_data   (w_main_data),
    .o_ctrl   (w_main_ctrl)
  );

  if (SKID != 0) begin : g_skid
    pipe_stage_hs_slot #(
      .DATA_W   (DATA_W),
      .CTRL_W   (CTRL_W),
      .CLR_DATA (CLR_DATA)
    ) u_skid (
      .i_clk    (i_clk),
      .i_clr    (w_clr),
      .i_load   (w_skid_load),
      .i_unload (w_skid_unload),
      .i_data   (i_up.data),
      .i_ctrl   (i_up.ctrl),
      .o_valid  (w_skid_valid),
      .o_data   (w_skid_data),
      .o_ctrl   (w_skid_ctrl)
    );
  end else begin : g_no_skid
    assign w_skid_valid = 1'b0;
    assign w_skid_data  = '0;
    assign w_skid_ctrl  = '0;
  end

  assign i_up.ready  = w_in_ready;
  assign o_dn.valid  = w_main_valid;
  assign o_dn.data   = w_main_data;
  assign o_dn.ctrl   = w_main_valid ? w_main_ctrl : '0;
  assign o_occupancy = 2'(w_main_valid) + 2'(w_skid_valid);

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Bench for pipe_stage_hs: one SKID=1 instance (directed + random with flush) and one
// SKID=0 instance (random, no flush). Each has a FIFO reference model and a monitor.
module tb_pipe_stage_hs;
  import pipe_stage_hs_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 8;
  typedef logic [DW+CW-1:0] ent_t;

  logic       clk = 1'b0;
  logic       rst1, flush1, rst0, flush0;
  logic [1:0] occ1, occ0;

  always #5 clk = ~clk;

  pipe_stage_hs_if #(.DATA_W(DW), .CTRL_W(CW)) up1 ();
  pipe_stage_hs_if #(.DATA_W(DW), .CTRL_W(CW)) dn1 ();
  pipe_stage_hs_if #(.DATA_W(DW), .CTRL_W(CW)) up0 ();
  pipe_stage_hs_if #(.DATA_W(DW), .CTRL_W(CW)) dn0 ();

  pipe_stage_hs #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CLR_DATA(1)) dut (
    .i_clk       (clk),
    .i_reset     (rst1),
    .i_flush     (flush1),
    .i_up        (up1),
    .o_dn        (dn1),
    .o_occupancy (occ1)
  );

  pipe_stage_hs #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CLR_DATA(1)) dut0 (
    .i_clk       (clk),
    .i_reset     (rst0),
    .i_flush     (flush0),
    .i_up        (up0),
    .o_dn        (dn0),
    .o_occupancy (occ0)
  );

  int   n_cmp = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;
  ent_t q1[$];
  ent_t q0[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model for SKID=1: a FIFO of capacity 2, accepting whenever it holds fewer than 2.
  bit   stall1 = 1'b0;
  ent_t held1;
  always @(negedge clk) begin
    if (mon_en) begin
      ent_t cur;
      bit   acc;
      cur = {dn1.ctrl, dn1.data};
      acc = up1.valid && (q1.size() < 2);
      chk("d1_occupancy", 64'(occ1), 64'(q1.size()));
      chk("d1_out_valid", 64'(dn1.valid), 64'(q1.size() != 0));
      chk("d1_in_ready", 64'(up1.ready), 64'(q1.size() < 2));
      if (!dn1.valid) chk("d1_ctrl_idle", 64'(dn1.ctrl), 64'd0);
      if (stall1) chk("d1_stall_hold", 64'(cur), 64'(held1));
      if (dn1.valid && dn1.ready) begin
        if (q1.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL d1_out: got %0h, expected no entry (t=%0t)", cur, $time);
        end else begin
          chk("d1_out", 64'(cur), 64'(q1.pop_front()));
        end
      end
      if (acc && !flush1 && !rst1) q1.push_back({up1.ctrl, up1.data});
      if (flush1 || rst1) q1.delete();
      stall1 = dn1.valid && !dn1.ready && !flush1 && !rst1;
      held1  = cur;
    end
  end

  // Model for SKID=0: single entry; accepts when empty or when the head leaves this cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      ent_t cur;
      bit   acc;
      cur = {dn0.ctrl, dn0.data};
      acc = up0.valid && ((q0.size() == 0) || dn0.ready);
      chk("d0_occupancy", 64'(occ0), 64'(q0.size()));
      chk("d0_out_valid", 64'(dn0.valid), 64'(q0.size() != 0));
      chk("d0_in_ready_rule", 64'(up0.ready), 64'(!dn0.valid || dn0.ready));
      if (!dn0.valid) chk("d0_ctrl_idle", 64'(dn0.ctrl), 64'd0);
      if (dn0.valid && dn0.ready) begin
        if (q0.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL d0_out: got %0h, expected no entry (t=%0t)", cur, $time);
        end else begin
          chk("d0_out", 64'(cur), 64'(q0.pop_front()));
        end
      end
      if (acc && !flush0 && !rst0) q0.push_back({up0.ctrl, up0.data});
      if (flush0 || rst0) q0.delete();
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [CW-1:0] c_rw;
    c_rw = '0;
    c_rw[CTRL_REGWRITE] = 1'b1;

    rst1 = 1'b1;  flush1 = 1'b0;  rst0 = 1'b1;  flush0 = 1'b0;
    up1.valid = 1'b1;  up1.data = 32'h1234;  up1.ctrl = c_rw;  dn1.ready = 1'b0;
    up0.valid = 1'b0;  up0.data = '0;        up0.ctrl = '0;    dn0.ready = 1'b0;

    // 1) reset held two cycles with in_valid high
    step();
    mon_en = 1'b1;
    step();
    rst1 = 1'b0;
    rst0 = 1'b0;
    up1.valid = 1'b0;
    chk("t1_out_valid", 64'(dn1.valid), 64'd0);
    chk("t1_out_ctrl", 64'(dn1.ctrl), 64'd0);
    chk("t1_occupancy", 64'(occ1), 64'd0);
    chk("t1_in_ready", 64'(up1.ready), 64'd1);
    chk("t1_out_data", 64'(dn1.data), 64'd0);

    // 2) back-to-back stream 1..8, downstream always ready
    dn1.ready = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      if (i > 1) begin
        chk("t2_valid", 64'(dn1.valid), 64'd1);
        chk("t2_data", 64'(dn1.data), 64'(i - 1));
      end
      if (i <= 8) begin
        up1.valid = 1'b1;
        up1.data  = DW'(i);
        up1.ctrl  = c_rw;
      end else begin
        up1.valid = 1'b0;
      end
      step();
    end
    chk("t2_drained", 64'(dn1.valid), 64'd0);

    // 3) stall with A in main, B in skid, C waiting upstream
    dn1.ready = 1'b0;
    up1.valid = 1'b1;  up1.data = 32'hA;
    step();
    up1.data = 32'hB;
    step();
    up1.data = 32'hC;
    for (int k = 0; k < 3; k++) begin
      chk("t3_occupancy", 64'(occ1), 64'd2);
      chk("t3_in_ready", 64'(up1.ready), 64'd0);
      chk("t3_hold_a", 64'(dn1.data), 64'hA);
      step();
    end
    dn1.ready = 1'b1;
    step();
    chk("t3_next_b", 64'(dn1.data), 64'hB);
    chk("t3_occ_after_release", 64'(occ1), 64'd1);
    step();
    up1.valid = 1'b0;
    chk("t3_next_c", 64'(dn1.data), 64'hC);
    step();
    chk("t3_empty", 64'(dn1.valid), 64'd0);

    // 4) flush with both entries held and an incoming 0xD
    dn1.ready = 1'b0;
    up1.valid = 1'b1;  up1.data = 32'h11;
    step();
    up1.data = 32'h22;
    step();
    chk("t4_occ_full", 64'(occ1), 64'd2);
    up1.data = 32'hD;
    flush1 = 1'b1;
    step();
    flush1 = 1'b0;
    up1.valid = 1'b0;
    chk("t4_out_valid", 64'(dn1.valid), 64'd0);
    chk("t4_occupancy", 64'(occ1), 64'd0);
    chk("t4_out_ctrl", 64'(dn1.ctrl), 64'd0);
    chk("t4_out_data_clr", 64'(dn1.data), 64'd0);
    dn1.ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t4_no_d", 64'(dn1.valid), 64'd0);
    end
    // flush while ready: the same-cycle in_fire of 0xD is discarded
    dn1.ready = 1'b0;
    up1.valid = 1'b1;  up1.data = 32'h33;
    step();
    up1.data = 32'hD;
    flush1 = 1'b1;
    step();
    flush1 = 1'b0;
    up1.valid = 1'b0;
    chk("t4b_occupancy", 64'(occ1), 64'd0);
    step();
    chk("t4b_no_d", 64'(dn1.valid), 64'd0);

    // 5) reset and flush together with an in_fire
    up1.valid = 1'b1;  up1.data = 32'h44;
    step();
    rst1 = 1'b1;  flush1 = 1'b1;  up1.data = 32'h55;
    step();
    rst1 = 1'b0;  flush1 = 1'b0;  up1.valid = 1'b0;
    chk("t5_in_ready", 64'(up1.ready), 64'd1);
    chk("t5_out_valid", 64'(dn1.valid), 64'd0);
    chk("t5_occupancy", 64'(occ1), 64'd0);
    chk("t5_out_data", 64'(dn1.data), 64'd0);
    chk("t5_out_ctrl", 64'(dn1.ctrl), 64'd0);

    // 6) random traffic: SKID=1 with occasional flush, SKID=0 without
    for (int n = 0; n < 10000; n++) begin
      up1.valid = 1'($urandom_range(0, 1));
      up1.data  = $urandom;
      up1.ctrl  = CW'($urandom);
      dn1.ready = ($urandom_range(0, 3) != 0);
      flush1    = ($urandom_range(0, 99) == 0);
      up0.valid = 1'($urandom_range(0, 1));
      up0.data  = $urandom;
      up0.ctrl  = CW'($urandom);
      dn0.ready = 1'($urandom_range(0, 1));
      step();
    end
    up1.valid = 1'b0;  flush1 = 1'b0;  dn1.ready = 1'b1;
    up0.valid = 1'b0;  dn0.ready = 1'b1;
    step();
    step();
    step();
    chk("end_d1_drained", 64'(q1.size()), 64'(occ1));
    chk("end_d0_drained", 64'(q0.size()), 64'(occ0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
